// File: rtl/vram_port_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vram_port_arbiter_pkg : shared arbiter state encoding and widths    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package vram_port_arbiter_pkg;

  // Statistics width, shared with the FSX status registers
  localparam int STAT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/vram_port_arbiter_sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vram_port_arbiter_sat_counter : saturating up-counter, sync clear  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module vram_port_arbiter_sat_counter
  import vram_port_arbiter_pkg::*;
#(
  parameter int WIDTH = STAT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/vram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vram_port_arbiter : GPU-priority sharing of one VRAM port with CPU |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module vram_port_arbiter
  import vram_port_arbiter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ADDR_BITS = 17,
  parameter int MAX_WAIT  = 1023
) (
  input  logic                  clkPixel,
  input  logic                  nreset,
  input  logic                  gpu_re,
  input  logic [ADDR_BITS-1:0]  gpu_addr,
  output logic [WIDTH-1:0]      gpu_q,
  input  logic                  cpu_start,
  input  logic                  cpu_we,
  input  logic [ADDR_BITS-1:0]  cpu_addr,
  input  logic [WIDTH-1:0]      cpu_d,
  output logic [WIDTH-1:0]      cpu_q,
  output logic                  cpu_busy,
  output logic                  cpu_done,
  output logic                  cpu_timeout,
  output logic [STAT_WIDTH-1:0] cpu_wait_max,
  input  logic                  clr_stats,
  output logic [ADDR_BITS-1:0]  ram_addr,
  output logic [WIDTH-1:0]      ram_d,
  output logic                  ram_we,
  input  logic [WIDTH-1:0]      ram_q
);

  localparam logic [STAT_WIDTH-1:0] C_MAX_WAIT = STAT_WIDTH'(MAX_WAIT);

  state_t                r_state;
  state_t                w_state_next;
  logic                  w_accept;
  logic                  w_grant;
  logic                  w_wait_inc;
  logic [STAT_WIDTH-1:0] w_wait;

  logic                  r_req_we;
  logic [ADDR_BITS-1:0]  r_req_addr;
  logic [WIDTH-1:0]      r_req_d;
  logic [WIDTH-1:0]      r_cpu_q;
  logic                  r_cpu_done;
  logic                  r_timeout;
  logic [STAT_WIDTH-1:0] r_wait_max;

  always_ff @(posedge clkPixel or negedge nreset) begin
    if (!nreset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_grant      = 1'b0;
    w_wait_inc   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cpu_start) begin
          w_accept     = 1'b1;
          w_state_next = ST_PEND;
        end
      end
      ST_PEND: begin
        // The GPU fetch schedule is fixed, so any GPU read steals the cycle
        if (gpu_re) begin
          w_wait_inc = 1'b1;
        end else begin
          w_grant      = 1'b1;
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  vram_port_arbiter_sat_counter #(
    .WIDTH (STAT_WIDTH)
  ) u_wait_cnt (
    .clk     (clkPixel),
    .rst_n   (nreset),
    .i_clr   (w_accept),
    .i_en    (w_wait_inc),
    .o_count (w_wait)
  );

  always_ff @(posedge clkPixel or negedge nreset) begin
    if (!nreset) begin
      r_req_we   <= 1'b0;
      r_req_addr <= '0;
      r_req_d    <= '0;
      r_cpu_q    <= '0;
      r_cpu_done <= 1'b0;
      r_timeout  <= 1'b0;
      r_wait_max <= '0;
    end else begin
      r_cpu_done <= (r_state == ST_RESP);
      if (w_accept) begin
        r_req_we   <= cpu_we;
        r_req_addr <= cpu_addr;
        r_req_d    <= cpu_d;
      end
      if ((r_state == ST_RESP) && !r_req_we) begin
        r_cpu_q <= ram_q;
      end
      // A clear in the same cycle as a completion update takes precedence
      if (clr_stats) begin
        r_timeout  <= 1'b0;
        r_wait_max <= '0;
      end else begin
        if ((r_state == ST_PEND) && (w_wait == C_MAX_WAIT)) begin
          r_timeout <= 1'b1;
        end
        if ((r_state == ST_RESP) && (w_wait > r_wait_max)) begin
          r_wait_max <= w_wait;
        end
      end
    end
  end

  assign ram_addr     = w_grant ? r_req_addr : gpu_addr;
  assign ram_d        = w_grant ? r_req_d : '0;
  assign ram_we       = w_grant & r_req_we;
  assign gpu_q        = ram_q;
  assign cpu_q        = r_cpu_q;
  assign cpu_busy     = (r_state != ST_IDLE);
  assign cpu_done     = r_cpu_done;
  assign cpu_timeout  = r_timeout;
  assign cpu_wait_max = r_wait_max;

endmodule
`default_nettype wire

// File: tb/tb_vram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_vram_port_arbiter : directed table, corner sequences and random |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_vram_port_arbiter;

  localparam int AW = 17;
  localparam int DW = 8;
  localparam int MW = 8;

  logic          clkPixel = 1'b0;
  logic          nreset   = 1'b0;
  logic          gpu_re   = 1'b0;
  logic [AW-1:0] gpu_addr = '0;
  logic [DW-1:0] gpu_q;
  logic          cpu_start = 1'b0;
  logic          cpu_we    = 1'b0;
  logic [AW-1:0] cpu_addr  = '0;
  logic [DW-1:0] cpu_d     = '0;
  logic [DW-1:0] cpu_q;
  logic          cpu_busy;
  logic          cpu_done;
  logic          cpu_timeout;
  logic [15:0]   cpu_wait_max;
  logic          clr_stats = 1'b0;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_d;
  logic          ram_we;
  logic [DW-1:0] ram_q;

  vram_port_arbiter #(
    .WIDTH     (DW),
    .ADDR_BITS (AW),
    .MAX_WAIT  (MW)
  ) dut (
    .clkPixel     (clkPixel),
    .nreset       (nreset),
    .gpu_re       (gpu_re),
    .gpu_addr     (gpu_addr),
    .gpu_q        (gpu_q),
    .cpu_start    (cpu_start),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_d        (cpu_d),
    .cpu_q        (cpu_q),
    .cpu_busy     (cpu_busy),
    .cpu_done     (cpu_done),
    .cpu_timeout  (cpu_timeout),
    .cpu_wait_max (cpu_wait_max),
    .clr_stats    (clr_stats),
    .ram_addr     (ram_addr),
    .ram_d        (ram_d),
    .ram_we       (ram_we),
    .ram_q        (ram_q)
  );

  always #5 clkPixel = ~clkPixel;

  // VRAM: registered read of the old contents, write on the same edge
  logic [DW-1:0] vram [0:(1<<AW)-1];
  initial begin
    ram_q = '0;
    for (int i = 0; i < (1 << AW); i++) vram[i] = '0;
    vram[17'h12C00] = 8'h3C;
    forever begin
      @(posedge clkPixel);
      ram_q <= vram[ram_addr];
      if (ram_we) vram[ram_addr] = ram_d;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: at most one outstanding request, served on the first
  // cycle without a GPU read; completion is reported one cycle later.
  logic [DW-1:0] gold [0:(1<<AW)-1];
  bit            m_out, m_granted, m_we, m_done, m_to, m_gqv;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_d, m_q, m_rd, m_gq;
  int            m_wait, m_wmax;

  task automatic model_reset();
    m_out = 0; m_granted = 0; m_we = 0; m_done = 0; m_to = 0; m_gqv = 0;
    m_addr = '0; m_d = '0; m_q = '0; m_rd = '0; m_gq = '0;
    m_wait = 0; m_wmax = 0;
  endtask

  task automatic model_check();
    bit grant;
    grant = m_out && !m_granted && !gpu_re;
    chk("busy", cpu_busy, m_out);
    chk("done", cpu_done, m_done);
    chk("ram_we", ram_we, grant && m_we);
    chk("ram_addr", ram_addr, grant ? m_addr : gpu_addr);
    chk("ram_d", ram_d, grant ? m_d : 8'h00);
    chk("cpu_q", cpu_q, m_q);
    chk("timeout", cpu_timeout, m_to);
    chk("wait_max", cpu_wait_max, m_wmax);
    if (m_gqv) chk("gpu_q", gpu_q, m_gq);
  endtask

  task automatic model_update();
    bit idle, pend, resp, grant;
    idle  = !m_out;
    pend  = m_out && !m_granted;
    resp  = m_out && m_granted;
    grant = pend && !gpu_re;
    m_done = resp;
    m_gqv  = gpu_re;
    if (gpu_re) m_gq = gold[gpu_addr];
    if (resp) begin
      if (!m_we) m_q = m_rd;
      if (m_wait > m_wmax) m_wmax = m_wait;
      m_out = 0;
    end
    if (clr_stats) begin
      m_to = 0;
      m_wmax = 0;
    end else if (pend && m_wait == MW) begin
      m_to = 1;
    end
    if (pend && gpu_re && m_wait < 65535) m_wait++;
    if (grant) begin
      m_granted = 1;
      m_rd = gold[m_addr];
      if (m_we) gold[m_addr] = m_d;
    end
    if (idle && cpu_start) begin
      m_out = 1; m_granted = 0; m_wait = 0;
      m_we = cpu_we; m_addr = cpu_addr; m_d = cpu_d;
    end
  endtask

  task automatic apply(input bit st, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit gre, input logic [AW-1:0] ga, input bit clr);
    cpu_start = st; cpu_we = we; cpu_addr = a; cpu_d = d;
    gpu_re = gre; gpu_addr = ga; clr_stats = clr;
    #4;
    model_check();
  endtask

  task automatic advance();
    model_update();
    @(posedge clkPixel);
    #1;
  endtask

  typedef struct {
    bit            st, we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit            gre;
    logic [AW-1:0] ga;
    bit            e_busy, e_done, e_we, qchk;
    logic [DW-1:0] e_q;
  } vec_t;

  function automatic vec_t mk(input bit st, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input bit gre, input bit e_busy, input bit e_done, input bit e_we,
                              input bit qchk, input logic [DW-1:0] e_q);
    vec_t v;
    v.st = st; v.we = we; v.a = a; v.d = d; v.gre = gre; v.ga = 17'h12C00;
    v.e_busy = e_busy; v.e_done = e_done; v.e_we = e_we; v.qchk = qchk; v.e_q = e_q;
    return v;
  endfunction

  vec_t tbl [24];

  initial begin
    for (int i = 0; i < (1 << AW); i++) gold[i] = '0;
    gold[17'h12C00] = 8'h3C;
    model_reset();

    // Uncontended write, then read of preloaded data
    tbl[0]  = mk(1, 1, 17'h00010, 8'hA5, 0, 0, 0, 0, 0, 8'h00);
    tbl[1]  = mk(0, 0, 17'h0,     8'h00, 0, 1, 0, 1, 0, 8'h00);
    tbl[2]  = mk(0, 0, 17'h0,     8'h00, 0, 1, 0, 0, 0, 8'h00);
    tbl[3]  = mk(0, 0, 17'h0,     8'h00, 0, 0, 1, 0, 0, 8'h00);
    tbl[4]  = mk(1, 0, 17'h12C00, 8'h00, 0, 0, 0, 0, 0, 8'h00);
    tbl[5]  = mk(0, 0, 17'h0,     8'h00, 0, 1, 0, 0, 0, 8'h00);
    tbl[6]  = mk(0, 0, 17'h0,     8'h00, 0, 1, 0, 0, 0, 8'h00);
    tbl[7]  = mk(0, 0, 17'h0,     8'h00, 0, 0, 1, 0, 1, 8'h3C);
    // Write held off by five GPU reads
    tbl[8]  = mk(1, 1, 17'h00020, 8'h5A, 0, 0, 0, 0, 0, 8'h3C);
    for (int i = 9; i <= 13; i++) tbl[i] = mk(0, 0, 17'h0, 8'h00, 1, 1, 0, 0, 0, 8'h3C);
    tbl[14] = mk(0, 0, 17'h0,     8'h00, 0, 1, 0, 1, 0, 8'h3C);
    tbl[15] = mk(0, 0, 17'h0,     8'h00, 0, 1, 0, 0, 0, 8'h3C);
    tbl[16] = mk(0, 0, 17'h0,     8'h00, 0, 0, 1, 0, 0, 8'h3C);
    // Start while pending is ignored; start in the done cycle is taken
    tbl[17] = mk(1, 0, 17'h00010, 8'h00, 0, 0, 0, 0, 0, 8'h3C);
    tbl[18] = mk(1, 1, 17'h00030, 8'hEE, 0, 1, 0, 0, 0, 8'h3C);
    tbl[19] = mk(0, 0, 17'h0,     8'h00, 0, 1, 0, 0, 0, 8'h3C);
    tbl[20] = mk(1, 0, 17'h00020, 8'h00, 0, 0, 1, 0, 1, 8'hA5);
    tbl[21] = mk(0, 0, 17'h0,     8'h00, 0, 1, 0, 0, 0, 8'hA5);
    tbl[22] = mk(0, 0, 17'h0,     8'h00, 0, 1, 0, 0, 0, 8'hA5);
    tbl[23] = mk(0, 0, 17'h0,     8'h00, 0, 0, 1, 0, 1, 8'h5A);

    // Reset state
    #12;
    chk("rst_busy", cpu_busy, 0);
    chk("rst_done", cpu_done, 0);
    chk("rst_timeout", cpu_timeout, 0);
    chk("rst_wait_max", cpu_wait_max, 0);
    chk("rst_cpu_q", cpu_q, 0);
    chk("rst_ram_we", ram_we, 0);
    @(posedge clkPixel);
    #1;
    nreset = 1'b1;

    for (int i = 0; i < 24; i++) begin
      apply(tbl[i].st, tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].gre, tbl[i].ga, 0);
      chk($sformatf("tbl%0d_busy", i), cpu_busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d_done", i), cpu_done, tbl[i].e_done);
      chk($sformatf("tbl%0d_ram_we", i), ram_we, tbl[i].e_we);
      if (tbl[i].e_we) chk($sformatf("tbl%0d_ram_addr", i), ram_addr, (i == 1) ? 17'h00010 : 17'h00020);
      if (tbl[i].qchk) chk($sformatf("tbl%0d_cpu_q", i), cpu_q, tbl[i].e_q);
      advance();
    end
    apply(0, 0, 0, 0, 0, 0, 0);
    chk("contended_wait_max", cpu_wait_max, 5);
    chk("ignored_write", vram[17'h00030], 8'h00);
    advance();

    // Timeout: 20 contended cycles with threshold 8
    apply(1, 1, 17'h00050, 8'hC3, 0, 0, 0);
    advance();
    for (int i = 0; i < 20; i++) begin
      apply(0, 0, 0, 0, 1, 17'h12C00, 0);
      if (i == 6) chk("timeout_early", cpu_timeout, 0);
      if (i == 12) chk("timeout_set", cpu_timeout, 1);
      advance();
    end
    apply(0, 0, 0, 0, 0, 0, 0);
    chk("timeout_grant_we", ram_we, 1);
    advance();
    apply(0, 0, 0, 0, 0, 0, 0);
    advance();
    apply(0, 0, 0, 0, 0, 0, 0);
    chk("timeout_done", cpu_done, 1);
    chk("timeout_held", cpu_timeout, 1);
    chk("timeout_wait_max", cpu_wait_max, 20);
    advance();
    apply(0, 0, 0, 0, 0, 0, 1);
    advance();
    apply(0, 0, 0, 0, 0, 0, 0);
    chk("clr_timeout", cpu_timeout, 0);
    chk("clr_wait_max", cpu_wait_max, 0);
    advance();

    // Random traffic with periodic GPU bursts
    for (int i = 0; i < 600; i++) begin
      bit gre;
      gre = ((i % 64) < 12) || ($urandom_range(0, 99) < 50);
      apply($urandom_range(0, 99) < 35, 1'($urandom_range(0, 1)),
            17'h00100 + 17'($urandom_range(0, 7)), 8'($urandom), gre,
            17'h00100 + 17'($urandom_range(0, 7)), $urandom_range(0, 99) < 3);
      advance();
    end

    // Reset while a request is pending
    for (int i = 0; i < 4; i++) begin
      apply(0, 0, 0, 0, 0, 0, 0);
      advance();
    end
    apply(1, 0, 17'h12C00, 8'h00, 0, 0, 0);
    advance();
    for (int i = 0; i < 10; i++) begin
      apply(0, 0, 0, 0, 1, 17'h12C00, 0);
      advance();
    end
    apply(0, 0, 0, 0, 1, 17'h12C00, 0);
    chk("pre_reset_busy", cpu_busy, 1);
    nreset = 1'b0;
    #1;
    chk("arst_busy", cpu_busy, 0);
    chk("arst_done", cpu_done, 0);
    chk("arst_timeout", cpu_timeout, 0);
    chk("arst_wait_max", cpu_wait_max, 0);
    chk("arst_cpu_q", cpu_q, 0);
    chk("arst_ram_we", ram_we, 0);
    model_reset();
    @(posedge clkPixel);
    #1;
    nreset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      apply(0, 0, 0, 0, 0, 0, 0);
      chk("post_reset_no_done", cpu_done, 0);
      chk("post_reset_no_we", ram_we, 0);
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
